// File: rtl/multicycle_controller.sv
// Multicycle control unit for a 16-bit processor.
// Latches a fetched instruction into ir and sequences
// BOOT -> FETCH -> DECODE -> EXECUTE -> (MEM -> (WRITEBACK)) -> FETCH.
// The data-memory request/ready handshake aborts after WAIT_MAX cycles.
// MUL/MULI stay in EXECUTE for MUL_LAT cycles.
// Optional build macro ILLEGAL_TRAP_EN adds an 'illegal' output. This output
// pulses in EXECUTE for undefined SPECIAL/SHIFT encodings, and those
// instructions then retire with only a PC update.
// Field decode and the mux controls are combinational from ir. Strobes depend
// on the registered state together with en and mem_ready, so a handshake
// completes in the same cycle that mem_ready is seen.

module multicycle_controller #(
    parameter int BOOT_CYCLES = 1,
    parameter int MUL_LAT     = 1,
    parameter int WAIT_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] instruction,
    input  logic        instr_valid,
    input  logic        mem_ready,
    output logic [3:0]  oper,
    output logic [3:0]  func,
    output logic [3:0]  cond,
    output logic [7:0]  immediate,
    output logic [3:0]  dstaddr,
    output logic [3:0]  srcaddr,
    output logic        alusrca,
    output logic        alusrcb,
    output logic        sign_ext_imm,
    output logic [1:0]  regsrc,
    output logic        pcsrc,
    output logic [1:0]  pcaddrsrc,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        mem_req,
    output logic        mem_err,
    output logic        busy
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        S_BOOT      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5
    } state_t;

    // Counter limits are stored as "last cycle index" so a compare ends the phase.
    localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] MUL_LAST  = 8'(MUL_LAT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] ir_q, ir_d;

    logic is_special_s, is_bcond_s, is_shift_s, is_jal_s, is_jcond_s, is_scond_s;
    logic is_load_s, is_stor_s, is_mul_s, is_muli_s, is_cmpi_s, is_reg_nowb_s;
    logic no_regwrite_s, illegal_enc_s;
    logic [7:0] exec_last_s;

    // Saturating increment: the phase counters never wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

`ifdef ILLEGAL_TRAP_EN
    // Undefined encodings within the SPECIAL and SHIFT opcode groups.
    function automatic logic illegal_check(input logic [3:0] op, input logic [3:0] fn);
        logic r;
        r = 1'b0;
        if (op == 4'b0100) begin
            r = !(fn == 4'b0000 || fn == 4'b0100 || fn == 4'b1000 ||
                  fn == 4'b1100 || fn == 4'b1101);
        end else if (op == 4'b1000) begin
            r = !(fn == 4'b0000 || fn == 4'b0001 || fn == 4'b0010 ||
                  fn == 4'b0011 || fn == 4'b0100 || fn == 4'b0110);
        end else begin
            r = 1'b0;
        end
        illegal_check = r;
    endfunction
    assign illegal_enc_s = illegal_check(ir_q[15:12], ir_q[7:4]);
`else
    assign illegal_enc_s = 1'b0;
`endif

    // Instruction class decode from the latched instruction.
    assign is_special_s  = (ir_q[15:12] == 4'b0100);
    assign is_bcond_s    = (ir_q[15:12] == 4'b1100);
    assign is_shift_s    = (ir_q[15:12] == 4'b1000);
    assign is_jal_s      = is_special_s && (ir_q[7:4] == 4'b1000);
    assign is_jcond_s    = is_special_s && (ir_q[7:4] == 4'b1100);
    assign is_scond_s    = is_special_s && (ir_q[7:4] == 4'b1101);
    assign is_load_s     = is_special_s && (ir_q[7:4] == 4'b0000);
    assign is_stor_s     = is_special_s && (ir_q[7:4] == 4'b0100);
    assign is_muli_s     = (ir_q[15:12] == 4'b1110);
    assign is_mul_s      = is_muli_s || ((ir_q[15:12] == 4'b0000) && (ir_q[7:4] == 4'b1110));
    assign is_cmpi_s     = (ir_q[15:12] == 4'b1011);
    assign is_reg_nowb_s = (ir_q[15:12] == 4'b0000) &&
                           ((ir_q[7:4] == 4'b0000) || (ir_q[7:4] == 4'b1011));
    assign no_regwrite_s = is_cmpi_s || is_bcond_s || is_reg_nowb_s || is_jcond_s;
    assign exec_last_s   = is_mul_s ? MUL_LAST : 8'd0;

    // Datapath field and mux-control decode.
    assign oper         = ir_q[15:12];
    assign func         = ir_q[7:4];
    assign cond         = is_scond_s ? ir_q[3:0] : ir_q[11:8];
    assign immediate    = ir_q[7:0];
    assign dstaddr      = ir_q[11:8];
    assign srcaddr      = ir_q[3:0];
    assign alusrca      = !(is_bcond_s || is_jal_s || is_jcond_s);
    assign alusrcb      = (ir_q[13:12] != 2'b00) ||
                          (is_shift_s && (ir_q[7:6] == 2'b00)) || is_bcond_s;
    assign sign_ext_imm = (((ir_q[15:14] == 2'b01) || (ir_q[15:14] == 2'b10)) &&
                           (ir_q[13:12] != 2'b00)) || is_bcond_s || is_muli_s;
    assign regsrc       = is_jal_s ? 2'b01 : (is_load_s ? 2'b10 : 2'b00);
    assign pcsrc        = !alusrca;
    assign pcaddrsrc    = {!pcwrite, (state_q == S_BOOT) ? 1'b0 : pcsrc};
    assign busy         = (state_q != S_FETCH);

    // State, phase counter and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
            cnt_q   <= 8'd0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, counter and strobe logic; en low freezes everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        pcwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        mem_req  = 1'b0;
        mem_err  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal  = 1'b0;
`endif
        if (en) begin
            case (state_q)
                S_BOOT: begin
                    if (cnt_q >= BOOT_LAST) begin
                        state_d = S_FETCH;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d   = sat_inc(cnt_q);
                    end
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_d    = instruction;
                        state_d = S_DECODE;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXECUTE;
                    cnt_d   = 8'd0;
                end
                S_EXECUTE: begin
                    if (cnt_q >= exec_last_s) begin
                        cnt_d = 8'd0;
                        if (illegal_enc_s) begin
                            pcwrite = 1'b1;
                            state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                            illegal = 1'b1;
`endif
                        end else if (is_load_s || is_stor_s) begin
                            state_d = S_MEM;
                        end else begin
                            pcwrite  = 1'b1;
                            regwrite = !no_regwrite_s;
                            state_d  = S_FETCH;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    memwrite = is_stor_s;
                    if (mem_ready) begin
                        cnt_d = 8'd0;
                        if (is_stor_s) begin
                            pcwrite = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WRITEBACK;
                        end
                    end else if (cnt_q >= WAIT_LAST) begin
                        mem_err = 1'b1;
                        pcwrite = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_FETCH;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                S_WRITEBACK: begin
                    regwrite = 1'b1;
                    pcwrite  = 1'b1;
                    state_d  = S_FETCH;
                end
                default: begin
                    state_d = S_BOOT;
                    cnt_d   = 8'd0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (BOOT_CYCLES=1, MUL_LAT=3, WAIT_MAX=4).
// Each stimulus cycle pushes the expected strobe vector
// {pcwrite, regwrite, memwrite, mem_req, mem_err, busy}, and the check pops it
// when the outputs settle.

module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst, en, instr_valid, mem_ready;
    logic [15:0] instruction;
    logic [3:0]  oper, func, cond, dstaddr, srcaddr;
    logic [7:0]  immediate;
    logic        alusrca, alusrcb, sign_ext_imm, pcsrc;
    logic [1:0]  regsrc, pcaddrsrc;
    logic        pcwrite, regwrite, memwrite, mem_req, mem_err, busy;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    multicycle_controller #(
        .BOOT_CYCLES(1),
        .MUL_LAT    (3),
        .WAIT_MAX   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .oper        (oper),
        .func        (func),
        .cond        (cond),
        .immediate   (immediate),
        .dstaddr     (dstaddr),
        .srcaddr     (srcaddr),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .sign_ext_imm(sign_ext_imm),
        .regsrc      (regsrc),
        .pcsrc       (pcsrc),
        .pcaddrsrc   (pcaddrsrc),
        .pcwrite     (pcwrite),
        .regwrite    (regwrite),
        .memwrite    (memwrite),
        .mem_req     (mem_req),
        .mem_err     (mem_err),
        .busy        (busy)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] strb;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, record expectation, compare before next posedge.
    task automatic cyc(input logic r, input logic e, input logic v, input logic [15:0] ins,
                       input logic mr, input logic [5:0] exp, input string tag);
        exp_t x;
        @(negedge clk);
        rst         = r;
        en          = e;
        instr_valid = v;
        instruction = ins;
        mem_ready   = mr;
        x.strb = exp;
        x.tag  = tag;
        sb_q.push_back(x);
        #2;
        x = sb_q.pop_front();
        check_eq(x.tag, {10'd0, pcwrite, regwrite, memwrite, mem_req, mem_err, busy},
                 {10'd0, x.strb});
    endtask

    task automatic fetch_decode(input logic [15:0] ins, input string tag);
        cyc(1'b0, 1'b1, 1'b1, ins,   1'b0, 6'b000000, {tag, "_fetch"});
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, {tag, "_decode"});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; instruction = 16'h0000;

        // Reset and boot
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "reset");
        check_eq("reset_oper", {12'd0, oper}, 16'h0000);
        check_eq("reset_pcaddrsrc", {14'd0, pcaddrsrc}, 16'h0002);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "boot");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000000, "fetch_idle");

        // ADDI
        fetch_decode(16'h5103, "addi");
        check_eq("addi_alusrcb", {15'd0, alusrcb}, 16'h0001);
        check_eq("addi_sext", {15'd0, sign_ext_imm}, 16'h0001);
        check_eq("addi_cond", {12'd0, cond}, 16'h0001);
        check_eq("addi_fields", {dstaddr, srcaddr, immediate}, 16'h1303);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "addi_exec");
        check_eq("addi_pcaddrsrc", {14'd0, pcaddrsrc}, 16'h0000);

        // LOAD, ready on third MEM cycle
        fetch_decode(16'h4204, "load");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "load_exec");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000101, "load_mem1");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000101, "load_mem2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 6'b000101, "load_mem3");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "load_wb");
        check_eq("load_regsrc", {14'd0, regsrc}, 16'h0002);

        // STOR timeout
        fetch_decode(16'h4241, "stor");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "stor_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b001101, "stor_mem_wait");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b101111, "stor_timeout");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000000, "stor_back_fetch");

        // STOR with ready arriving in the timeout cycle: ready wins
        fetch_decode(16'h4241, "stor2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "stor2_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b001101, "stor2_mem_wait");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 6'b101101, "stor2_ready_at_limit");

        // MULI, 3-cycle execute
        fetch_decode(16'hE305, "muli");
        check_eq("muli_sext", {15'd0, sign_ext_imm}, 16'h0001);
        check_eq("muli_alusrcb", {15'd0, alusrcb}, 16'h0001);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "muli_exec1");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "muli_exec2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "muli_exec3");

        // MUL register form, also 3 cycles
        fetch_decode(16'h02E3, "mul");
        check_eq("mul_sext", {15'd0, sign_ext_imm}, 16'h0000);
        check_eq("mul_alusrcb", {15'd0, alusrcb}, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "mul_exec1");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "mul_exec2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "mul_exec3");

        // CMPI: no register write
        fetch_decode(16'hB207, "cmpi");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b100001, "cmpi_exec");

        // BCOND
        fetch_decode(16'hC50A, "bcond");
        check_eq("bcond_ctl", {12'd0, alusrca, alusrcb, sign_ext_imm, pcsrc}, 16'h0007);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b100001, "bcond_exec");
        check_eq("bcond_pcaddrsrc", {14'd0, pcaddrsrc}, 16'h0001);

        // SCOND takes cond from the low nibble
        fetch_decode(16'h43D9, "scond");
        check_eq("scond_cond", {12'd0, cond}, 16'h0009);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "scond_exec");

        // JAL with en low for two EXECUTE cycles
        fetch_decode(16'h4580, "jal");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'b000001, "jal_en_low1");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'b000001, "jal_en_low2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b110001, "jal_exec");
        check_eq("jal_regsrc", {14'd0, regsrc}, 16'h0001);
        check_eq("jal_alusrca", {15'd0, alusrca}, 16'h0000);
        check_eq("jal_pcaddrsrc", {14'd0, pcaddrsrc}, 16'h0001);

        // LOAD timeout with en low in MEM: wait counter holds
        fetch_decode(16'h4204, "load2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "load2_exec");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000101, "load2_mem1");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'b000001, "load2_en_low1");
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'b000001, "load2_en_low2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000101, "load2_mem2");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000101, "load2_mem3");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b100111, "load2_timeout");

        // Reset in the middle of a STOR memory phase
        fetch_decode(16'h4241, "stor3");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b000001, "stor3_exec");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 6'b001101, "stor3_mem1");
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 6'b000001, "rst_mid_mem");
        check_eq("rst_mid_mem_ir", {12'd0, oper}, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 6'b000001, "rst_boot");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 6'b000000, "rst_fetch1");
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 6'b000000, "rst_fetch2");

        check_eq("sb_empty", 16'(sb_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised successor to the processor control unit: decodes a latched 16-bit instruction and sequences fetch, decode, execute, memory and writeback.
- Adds an instruction-fetch handshake, a data-memory request/ready handshake with timeout, and a configurable multiply latency.
- Sits between instruction/data memory ports and the datapath muxes (ALU, PC, register file).

Parameters:
- BOOT_CYCLES, 1, cycles held in BOOT after reset release (1..15)
- MUL_LAT, 1, EXECUTE cycles for MUL (oper 0000 func 1110) and MULI (oper 1110) (1..15)
- WAIT_MAX, 15, max MEM cycles awaiting mem_ready before abort (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global advance enable; low freezes state, counters and ir
- instruction  in  16  fetched instruction word
- instr_valid  in  1  instruction valid; sampled in FETCH
- mem_ready  in  1  data memory ready; completes the current request
- oper, func, cond  out  4 each  decoded fields from ir
- immediate  out  8  ir[7:0]
- dstaddr, srcaddr  out  4 each  ir[11:8], ir[3:0]
- alusrca, alusrcb, sign_ext_imm  out  1 each  datapath mux controls
- regsrc  out  2  00 ALU, 01 PC link (JAL), 10 memory (LOAD)
- pcsrc  out  1  !alusrca
- pcaddrsrc  out  2  [1]=!pcwrite; [0]=pcsrc, forced 0 in BOOT
- pcwrite, regwrite, memwrite  out  1 each  single-cycle strobes
- mem_req  out  1  data memory request
- mem_err  out  1  one-cycle pulse on memory timeout
- busy  out  1  high in every state except FETCH

Behaviour:
- Reset: state=BOOT, ir=16'h0000, counters=0, all strobes, mem_req and mem_err =0. Reset mid-instruction abandons it; no strobe fires.
- Field decode is combinational from ir only: oper=ir[15:12], func=ir[7:4], cond=ir[3:0] for SCOND (oper 0100 func 1101), else ir[11:8].
- alusrca=0 for BCOND (1100), JAL (0100/1000) and JCOND (0100/1100); else 1.
- alusrcb=1 when oper[1:0]!=00, when SHIFT (1000) with func[3:2]==00, or for BCOND.
- sign_ext_imm=1 when (oper[3:2] is 01 or 10) and oper[1:0]!=00, or for BCOND or MULI.
- BOOT: holds BOOT_CYCLES en-cycles, then FETCH.
- FETCH: when instr_valid=1, ir<=instruction and go to DECODE; otherwise stay.
- DECODE: 1 cycle, then EXECUTE.
- EXECUTE: 1 cycle, or MUL_LAT cycles for MUL/MULI. Then LOAD (0100/0000) and STOR (0100/0100) go to MEM; all other instructions go to FETCH.
- Final EXECUTE cycle of a non-memory instruction: pcwrite=1. regwrite=1 unless CMPI, BCOND, REGISTER func 0000 or 1011, or JCOND.
- MEM: mem_req=1 from the first cycle. memwrite=mem_req for STOR.
- MEM completion: exit on the cycle mem_ready=1. STOR asserts pcwrite that cycle and goes to FETCH; LOAD goes to WRITEBACK.
- MEM timeout: WAIT_MAX cycles without mem_ready gives mem_err=1, pcwrite=1, no regwrite, then FETCH. mem_ready in the same cycle as the timeout wins; no error.
- WRITEBACK: regwrite=1, pcwrite=1, then FETCH.
- en=0: all strobes, mem_req and mem_err are forced 0. State and counters hold. The MEM wait counter does not advance.
- Counters saturate at their limits; they never wrap.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: illegal encodings are SPECIAL func not in {0000,0100,1000,1100,1101} and SHIFT func not in {0000,0001,0010,0011,0100,0110}.
- For an illegal encoding, output illegal (1 bit) pulses in EXECUTE. regwrite and memwrite are suppressed, pcwrite still fires, and the next state is FETCH.
- Undefined: no illegal port; such encodings decode per the rules above.

Test Plan:
- Reset then ADDI 16'h5103 with instr_valid=1 -> BOOT 1 cycle; FETCH, DECODE, EXECUTE; pcwrite=regwrite=1 in EXECUTE; alusrcb=1, sign_ext_imm=1.
- LOAD 16'h4204 with mem_ready after 3 cycles -> mem_req high 3 cycles, memwrite=0; WRITEBACK asserts regwrite=1, regsrc=10, pcwrite=1.
- STOR 16'h4241, mem_ready never, WAIT_MAX=4 -> mem_req and memwrite high 4 cycles; mem_err pulse with pcwrite=1; regwrite=0.
- MULI 16'hE305 with MUL_LAT=3 -> EXECUTE 3 cycles; regwrite/pcwrite only in the third; sign_ext_imm=1.
- JAL 16'h4580 with en low 2 cycles during EXECUTE -> no strobes while en=0; then regsrc=01, alusrca=0, pcaddrsrc=01.
- rst asserted mid-MEM of a STOR -> outputs 0 immediately; BOOT; no memwrite after release.
